// File: rtl/ps2_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_fifo
//  Purpose  : PS/2 scan-byte front end. It pops bytes from the receiver with
//             a one-cycle active-low strobe, decodes the E0 and F0 prefixes
//             into make/break events, tracks the held key, counts presses and
//             queues the events in a valid/ready FIFO.
//  Options  : PS2_TYPEMATIC_FILTER_EN - when defined, a repeated make of the
//             key already held is not counted and not enqueued.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8
) (
   input  logic                               clk,
   input  logic                               clrn,
   // receiver side
   input  logic                               rx_ready,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_overflow,
   output logic                               rx_nextdata_n,
   // event stream
   output logic                               ev_valid,
   input  logic                               ev_ready,
   output logic [7:0]                         ev_code,
   output logic                               ev_ext,
   output logic                               ev_break,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   // status
   output logic [CNT_W-1:0]                   key_count,
   output logic                               held,
   output logic [8:0]                         held_code,
   output logic                               err_ovf
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   localparam logic [7:0]    c_byte_e0    = 8'hE0;
   localparam logic [7:0]    c_byte_f0    = 8'hF0;
   localparam logic [LW-1:0] c_full_level = LW'(FIFO_DEPTH);

   // Prefix state: which of E0 / F0 has been seen since the last event.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_E0   = 2'd1,
      ST_F0   = 2'd2,
      ST_E0F0 = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_nextdata_n;
   logic              w_accept;

   logic              w_make;
   logic              w_break;
   logic              w_ext;
   logic              w_repeat;
   logic              w_count_make;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_wr;
   logic              w_drop;
   logic              w_held_clear;
   logic [8:0]        w_key;

   logic [9:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;

   logic [CNT_W-1:0]  r_key_count;
   logic              r_held;
   logic [8:0]        r_held_code;
   logic              r_err_ovf;

   // ------------------------------------------------------------------------
   // Receiver handshake. The strobe register doubles as the ACK-cycle flag:
   // while it is low the receiver is still retiring the byte just taken, so
   // rx_ready is not trusted for that cycle.
   // ------------------------------------------------------------------------
   assign w_accept = rx_ready & r_nextdata_n;

   // Pop strobe: low for exactly the cycle after an accepting edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_nextdata_n <= 1'b1;
      end else begin
         r_nextdata_n <= ~w_accept;
      end
   end

   // ------------------------------------------------------------------------
   // Prefix decoder
   // ------------------------------------------------------------------------

   // Prefix state register; a reset drops any half-received sequence.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and event decode on each accepted byte.
   always_comb begin
      w_state_nxt = r_state;
      w_make      = 1'b0;
      w_break     = 1'b0;
      w_ext       = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (rx_data == c_byte_e0) begin
                  w_state_nxt = ST_E0;
               end else if (rx_data == c_byte_f0) begin
                  w_state_nxt = ST_F0;
               end else begin
                  w_make = 1'b1;
               end
            end
            ST_E0: begin
               if (rx_data == c_byte_f0) begin
                  w_state_nxt = ST_E0F0;
               end else if (rx_data != c_byte_e0) begin
                  w_make      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_F0: begin
               if (rx_data == c_byte_e0) begin
                  w_state_nxt = ST_E0F0;
               end else if (rx_data != c_byte_f0) begin
                  w_break     = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_E0F0: begin
               if ((rx_data != c_byte_e0) && (rx_data != c_byte_f0)) begin
                  w_break     = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign w_key = {w_ext, rx_data};

   // A make of the key that is already down is auto-repeat from the keyboard.
`ifdef PS2_TYPEMATIC_FILTER_EN
   assign w_repeat = w_make & r_held & (w_key == r_held_code);
`else
   assign w_repeat = 1'b0;
`endif

   assign w_count_make = w_make & ~w_repeat;
   assign w_push       = w_count_make | w_break;
   assign w_held_clear = w_break & r_held & (w_key == r_held_code);

   // ------------------------------------------------------------------------
   // Held key and press counter
   // ------------------------------------------------------------------------

   // Held key: the last make wins; only a matching release clears it.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_held      <= 1'b0;
         r_held_code <= 9'd0;
      end else if (w_count_make) begin
         r_held      <= 1'b1;
         r_held_code <= w_key;
      end else if (w_held_clear) begin
         r_held      <= 1'b0;
      end
   end

   // Press counter; wraps naturally at its width. Dropped events still count.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_key_count <= '0;
      end else if (w_count_make) begin
         r_key_count <= r_key_count + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Event FIFO. A push into a full queue is still taken when the head is
   // leaving on the same edge, so the queue never drops while it drains.
   // ------------------------------------------------------------------------
   assign w_full = (r_level == c_full_level);
   assign w_pop  = (r_level != '0) & ev_ready;
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_drop = w_push & w_full & ~w_pop;

   // Storage array: data only, validity is carried by the level counter.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {w_break, w_ext, rx_data};
      end
   end

   // Pointers and occupancy; equal push and pop leave the level unchanged.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr && !w_pop) begin
            r_level <= r_level + LW'(1);
         end else if (w_pop && !w_wr) begin
            r_level <= r_level - LW'(1);
         end
      end
   end

   // Sticky error: an event lost to a full queue or a receiver overrun.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_err_ovf <= 1'b0;
      end else if (w_drop || rx_overflow) begin
         r_err_ovf <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign rx_nextdata_n = r_nextdata_n;
   assign ev_valid      = (r_level != '0);
   assign ev_break      = r_mem[r_rd_ptr][9];
   assign ev_ext        = r_mem[r_rd_ptr][8];
   assign ev_code       = r_mem[r_rd_ptr][7:0];
   assign fifo_level    = r_level;
   assign key_count     = r_key_count;
   assign held          = r_held;
   assign held_code     = r_held_code;
   assign err_ovf       = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_event_fifo
//  Purpose  : Directed bench for ps2_key_event_fifo with a queue-based
//             reference model and a per-cycle output compare.
//  Options  : PS2_TYPEMATIC_FILTER_EN - must match the DUT build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_fifo;

   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 8;

   logic         clk = 1'b0;
   logic         clrn = 1'b0;
   logic         rx_ready = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_overflow = 1'b0;
   logic         rx_nextdata_n;
   logic         ev_valid;
   logic         ev_ready = 1'b0;
   logic [7:0]   ev_code;
   logic         ev_ext;
   logic         ev_break;
   logic [3:0]   fifo_level;
   logic [7:0]   key_count;
   logic         held;
   logic [8:0]   held_code;
   logic         err_ovf;

   int n_checks = 0;
   int n_pass   = 0;
   int n_low    = 0;

   ps2_key_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .clrn(clrn),
      .rx_ready(rx_ready), .rx_data(rx_data), .rx_overflow(rx_overflow),
      .rx_nextdata_n(rx_nextdata_n),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .fifo_level(fifo_level),
      .key_count(key_count), .held(held), .held_code(held_code),
      .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [9:0] m_q[$];
   bit         m_ack      = 0;
   bit         m_seen_e0  = 0;
   bit         m_seen_f0  = 0;
   logic [7:0] m_count    = 0;
   bit         m_held     = 0;
   logic [8:0] m_held_code = 0;
   bit         m_err      = 0;

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         m_q.delete();
         m_ack = 0; m_seen_e0 = 0; m_seen_f0 = 0;
         m_count = 0; m_held = 0; m_held_code = 0; m_err = 0;
      end else begin
         bit accept, is_ev, brk, ext, push, pop, full;
         logic [8:0] key;
         accept = rx_ready && !m_ack;
         is_ev = 0; brk = 0; ext = 0; push = 0;
         if (accept) begin
            if (rx_data == 8'hE0) m_seen_e0 = 1;
            else if (rx_data == 8'hF0) m_seen_f0 = 1;
            else begin
               is_ev = 1; ext = m_seen_e0; brk = m_seen_f0;
               m_seen_e0 = 0; m_seen_f0 = 0;
            end
         end
         key = {ext, rx_data};
         if (is_ev && !brk) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!(m_held && key == m_held_code)) begin
`else
            begin
`endif
               push = 1;
               m_count = m_count + 8'd1;
               m_held = 1; m_held_code = key;
            end
         end else if (is_ev && brk) begin
            push = 1;
            if (m_held && key == m_held_code) m_held = 0;
         end
         full = (m_q.size() == FIFO_DEPTH);
         pop  = (m_q.size() > 0) && ev_ready;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (!full || pop) m_q.push_back({brk, ext, rx_data});
            else m_err = 1;
         end
         if (rx_overflow) m_err = 1;
         m_ack = accept;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rx_nextdata_n === 1'b0) n_low++;
      check("nextdata_n", rx_nextdata_n, !m_ack);
      check("ev_valid", ev_valid, m_q.size() > 0);
      check("fifo_level", fifo_level, m_q.size());
      check("key_count", key_count, m_count);
      check("held", held, m_held);
      check("held_code", held_code, m_held_code);
      check("err_ovf", err_ovf, m_err);
      if (m_q.size() > 0) check("head", {ev_break, ev_ext, ev_code}, m_q[0]);
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      #1 clrn = 1'b0; rx_ready = 1'b0; ev_ready = 1'b0; rx_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
   endtask

   // Present a byte until the pop strobe shows it was taken; returns 1 ns
   // after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (rx_nextdata_n == 1'b0) break;
      end
      check("rx_accept", rx_nextdata_n, 1'b0);
      rx_ready = 1'b0;
   endtask

   task automatic pop_expect(input logic brk, input logic ext, input logic [7:0] code);
      check("pop_valid", ev_valid, 1'b1);
      check("pop_fields", {ev_break, ev_ext, ev_code}, {brk, ext, code});
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
   endtask

   task automatic drain();
      ev_ready = 1'b1;
      for (int i = 0; i < 20 && ev_valid; i++) begin
         @(posedge clk); #1;
      end
      ev_ready = 1'b0;
      check("drained", ev_valid, 1'b0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int low0;
      apply_reset();
      check("rst_level", fifo_level, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_nextdata", rx_nextdata_n, 1);

      // make then break of 1C
      low0 = n_low;
      send_byte(8'h1C);
      check("t1_held_set", held, 1);
      send_byte(8'hF0);
      send_byte(8'h1C);
      repeat (2) @(posedge clk); #1;
      check("t1_low_count", n_low - low0, 3);
      check("t1_count", key_count, 1);
      check("t1_held_clr", held, 0);
      check("t1_level", fifo_level, 2);
      pop_expect(1'b0, 1'b0, 8'h1C);
      pop_expect(1'b1, 1'b0, 8'h1C);

      // extended key 75
      apply_reset();
      send_byte(8'hE0);
      @(posedge clk); #1;
      check("t2_no_ev_prefix", ev_valid, 0);
      send_byte(8'h75);
      check("t2_held_code", held_code, 9'h175);
      send_byte(8'hE0);
      send_byte(8'hF0);
      @(posedge clk); #1;
      check("t2_level_prefix", fifo_level, 1);
      send_byte(8'h75);
      @(posedge clk); #1;
      check("t2_held_clr", held, 0);
      pop_expect(1'b0, 1'b1, 8'h75);
      pop_expect(1'b1, 1'b1, 8'h75);

      // typematic repeat
      apply_reset();
      send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h1C);
      @(posedge clk); #1;
`ifdef PS2_TYPEMATIC_FILTER_EN
      check("t3_count", key_count, 1);
      check("t3_level", fifo_level, 2);
`else
      check("t3_count", key_count, 3);
      check("t3_level", fifo_level, 4);
`endif
      drain();

      // overflow: 9 makes with no consumer
      apply_reset();
      for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
      @(posedge clk); #1;
      check("t4_level", fifo_level, 8);
      check("t4_err", err_ovf, 1);
      check("t4_count", key_count, 9);
      for (int i = 0; i < 8; i++) pop_expect(1'b0, 1'b0, 8'h15 + 8'(i));
      check("t4_empty", fifo_level, 0);

      // full with pop and push on the same edge
      apply_reset();
      for (int i = 0; i < 8; i++) send_byte(8'h15 + 8'(i));
      @(posedge clk); #1;
      rx_data = 8'h2A; rx_ready = 1'b1; ev_ready = 1'b1;
      @(posedge clk); #1;
      check("t5_accept", rx_nextdata_n, 0);
      rx_ready = 1'b0; ev_ready = 1'b0;
      check("t5_level", fifo_level, 8);
      check("t5_err", err_ovf, 0);
      for (int i = 1; i < 8; i++) pop_expect(1'b0, 1'b0, 8'h15 + 8'(i));
      pop_expect(1'b0, 1'b0, 8'h2A);

      // receiver overflow flag
      rx_overflow = 1'b1;
      @(posedge clk); #1;
      rx_overflow = 1'b0;
      check("t6_rx_ovf", err_ovf, 1);

      // asynchronous reset after a break prefix
      apply_reset();
      send_byte(8'h1C);
      send_byte(8'hF0);
      #2 clrn = 1'b0;
      #1;
      check("t7_async_nextdata", rx_nextdata_n, 1);
      check("t7_async_valid", ev_valid, 0);
      check("t7_async_count", key_count, 0);
      check("t7_async_held", {held, held_code}, 0);
      #2 clrn = 1'b1;
      send_byte(8'h1C);
      @(posedge clk); #1;
      check("t7_count", key_count, 1);
      check("t7_make", {ev_valid, ev_break, ev_code}, {1'b1, 1'b0, 8'h1C});
      drain();

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
